// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types, constants and helpers for the handshaked PISO
//               serializer (state encoding, counter width, idle level).
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    // Serializer control states; explicit one-bit encoding.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Line level when no frame is on the wire.
    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

    // Bit-counter width: enough to count DATA_W-1 down to 0, never below 1.
    function automatic int cnt_width(input int data_w);
        int w;
        w = $clog2(data_w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : piso_hold_buf
// Description : One-entry holding register (word + bit-order flag + full).
//               Lets the next word wait while the current one shifts out.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_hold_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_lsb_first,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic              lsb_first
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic              r_lsb_first;

    // Flush empties the slot; push only happens while empty, pop only while full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full      <= 1'b0;
            r_data      <= '0;
            r_lsb_first <= 1'b0;
        end else if (flush) begin
            r_full      <= 1'b0;
            r_data      <= '0;
            r_lsb_first <= 1'b0;
        end else if (push) begin
            r_full      <= 1'b1;
            r_data      <= push_data;
            r_lsb_first <= push_lsb_first;
        end else if (pop) begin
            r_full      <= 1'b0;
        end
    end

    assign full      = r_full;
    assign data      = r_data;
    assign lsb_first = r_lsb_first;

endmodule
`default_nettype wire

// File: rtl/piso_serializer_hs.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_hs
// Description : Parametrised parallel-in/serial-out serializer with a
//               valid/ready input, per-word bit order and a one-entry hold
//               buffer so consecutive frames leave with no idle bit between.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer_hs
    import piso_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT,
    parameter int   CNT_W      = cnt_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_lsb_first,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DATA_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_lsb;
    logic              w_lsb_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic              w_hold_full;
    logic [DATA_W-1:0] w_hold_data;
    logic              w_hold_lsb;
    logic              w_accept;
    logic              w_last;
    logic              w_load_direct;
    logic              w_push;
    logic              w_pop;

    // A word may come in only when the hold slot is free and no abort is active.
    assign in_ready = !w_hold_full && !flush;
    assign w_accept = in_valid && in_ready;

    // Last bit of the running frame is consumed this cycle.
    assign w_last = (r_state == SHIFT) && enable && (r_cnt == '0);

    // Straight to the shifter when idle or when the frame ends with nothing
    // waiting; otherwise park the word in the hold slot.
    assign w_load_direct = w_accept && ((r_state == IDLE) || w_last);
    assign w_push        = w_accept && !w_load_direct;
    assign w_pop         = w_last && w_hold_full && !flush;

    piso_hold_buf #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk            (clk),
        .reset_n        (reset_n),
        .push           (w_push),
        .pop            (w_pop),
        .flush          (flush),
        .push_data      (in_data),
        .push_lsb_first (in_lsb_first),
        .full           (w_hold_full),
        .data           (w_hold_data),
        .lsb_first      (w_hold_lsb)
    );

    // Next-state logic: flush aborts, enabled shifts advance, frame end reloads.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_lsb_nxt   = r_lsb;
        w_done_nxt  = 1'b0;
        if (flush) begin
            w_state_nxt = IDLE;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
        end else if (r_state == SHIFT) begin
            if (enable) begin
                if (r_cnt != '0) begin
                    w_shift_nxt = r_lsb ? {1'b0, r_shift[DATA_W-1:1]}
                                        : {r_shift[DATA_W-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end else begin
                    w_done_nxt = 1'b1;
                    if (w_hold_full) begin
                        w_shift_nxt = w_hold_data;
                        w_lsb_nxt   = w_hold_lsb;
                        w_cnt_nxt   = c_cnt_max;
                    end else if (w_accept) begin
                        w_shift_nxt = in_data;
                        w_lsb_nxt   = in_lsb_first;
                        w_cnt_nxt   = c_cnt_max;
                    end else begin
                        w_state_nxt = IDLE;
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
                    end
                end
            end
        end else if (w_accept) begin
            // Loading from idle does not wait for an enable tick.
            w_state_nxt = SHIFT;
            w_shift_nxt = in_data;
            w_lsb_nxt   = in_lsb_first;
            w_cnt_nxt   = c_cnt_max;
        end
    end

    // State, shifter, counter, bit order and done-pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_lsb   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lsb   <= w_lsb_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Output muxing: the bit at the output end of the shifter, idle level otherwise.
    always_comb begin
        serial_valid = (r_state == SHIFT);
        serial_out   = IDLE_LEVEL;
        if (r_state == SHIFT) begin
            serial_out = r_lsb ? r_shift[0] : r_shift[DATA_W-1];
        end
    end

    assign frame_start = (r_state == SHIFT) && (r_cnt == c_cnt_max);
    assign frame_done  = r_done;
    assign busy        = (r_state == SHIFT) || w_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer_hs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_piso_serializer_hs
// Description : Self-checking bench for piso_serializer_hs. A bit-queue
//               reference model predicts every output each cycle through
//               directed scenarios followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer_hs;

    localparam int   DATA_W  = 8;
    localparam logic TB_IDLE = 1'b1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_lsb_first;
    logic              serial_out;
    logic              serial_valid;
    logic              frame_start;
    logic              frame_done;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bits still to be sent for the current frame (front is
    // on the wire), an optional waiting word, and the pending done pulse.
    bit                m_cur[$];
    logic [DATA_W-1:0] m_hold_d[$];
    bit                m_hold_l[$];
    bit                m_done = 1'b0;

    always #5 clk = ~clk;

    piso_serializer_hs #(
        .DATA_W     (DATA_W),
        .IDLE_LEVEL (TB_IDLE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_lsb_first (in_lsb_first),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cur    = {};
        m_hold_d = {};
        m_hold_l = {};
        m_done   = 1'b0;
    endtask

    task automatic model_load(input logic [DATA_W-1:0] w, input bit lsb);
        m_cur = {};
        for (int i = 0; i < DATA_W; i++) begin
            m_cur.push_back(lsb ? w[i] : w[DATA_W-1-i]);
        end
    endtask

    task automatic check_outputs(input logic fl);
        bit   exp_valid;
        logic exp_out;
        exp_valid = (m_cur.size() > 0);
        exp_out   = exp_valid ? m_cur[0] : TB_IDLE;
        check("serial_out",   serial_out,   exp_out);
        check("serial_valid", serial_valid, exp_valid);
        check("frame_start",  frame_start,  m_cur.size() == DATA_W);
        check("frame_done",   frame_done,   m_done);
        check("in_ready",     in_ready,     (m_hold_d.size() == 0) && !fl);
        check("busy",         busy,         exp_valid || (m_hold_d.size() > 0));
    endtask

    task automatic model_update(input logic v, input logic [DATA_W-1:0] d,
                                input logic l, input logic en, input logic fl);
        bit valid;
        bit acc;
        bit last;
        valid = (m_cur.size() > 0);
        acc   = v && (m_hold_d.size() == 0) && !fl;
        last  = valid && en && (m_cur.size() == 1);
        if (fl) begin
            model_clear();
        end else begin
            m_done = last;
            if (valid && en) void'(m_cur.pop_front());
            if (m_cur.size() == 0) begin
                if (m_hold_d.size() > 0) begin
                    model_load(m_hold_d[0], m_hold_l[0]);
                    m_hold_d = {};
                    m_hold_l = {};
                end else if (acc) begin
                    model_load(d, l);
                    acc = 1'b0;
                end
            end
            if (acc) begin
                m_hold_d.push_back(d);
                m_hold_l.push_back(l);
            end
        end
    endtask

    // One clock: apply inputs, check outputs mid-cycle, clock, advance model.
    task automatic tick(input logic v, input logic [DATA_W-1:0] d, input logic l,
                        input logic en, input logic fl);
        in_valid     = v;
        in_data      = d;
        in_lsb_first = l;
        enable       = en;
        flush        = fl;
        #1;
        check_outputs(fl);
        @(posedge clk);
        model_update(v, d, l, en, fl);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_values();
        check("rst_serial_out",   serial_out,   TB_IDLE);
        check("rst_serial_valid", serial_valid, 1'b0);
        check("rst_frame_start",  frame_start,  1'b0);
        check("rst_frame_done",   frame_done,   1'b0);
        check("rst_in_ready",     in_ready,     1'b1);
        check("rst_busy",         busy,         1'b0);
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_lsb_first = 1'b0;
        model_clear();
        #7;
        check_reset_values();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 0xA5 MSB first, then return to idle.
        tick(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
        idle_ticks(10);

        // 0x0F LSB first.
        tick(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0);
        idle_ticks(10);

        // Back-to-back 0xF0 / 0x3C; extra word offered while hold is full.
        tick(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        idle_ticks(20);

        // 0xC3 with enable toggling every cycle.
        tick(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, '0, 1'b0, (i % 2) == 0, 1'b0);
        idle_ticks(2);

        // Flush mid-frame with the hold slot occupied.
        tick(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        idle_ticks(12);

        // Asynchronous reset in the middle of a frame, then a fresh word.
        tick(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        idle_ticks(3);
        in_valid = 1'b0;
        enable   = 1'b1;
        flush    = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
        idle_ticks(10);

        // Randomized traffic: mostly-enabled ticks, bursty valid, rare flush.
        for (int i = 0; i < 500; i++) begin
            tick(1'($urandom_range(0, 1)),
                 8'($urandom()),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0));
        end
        idle_ticks(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
